// File: rtl/sized_data_memory.sv
// Byte-addressable 32-bit data memory with byte/half/word access,
// optional clear-after-reset and a single-outstanding valid/ready port.
module sized_data_memory #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_Data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           read_Data,
  output logic                  rsp_error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH];

  logic [AW-1:0]   widx;
  logic [1:0]      lane;
  logic            oob;
  logic            req_err;
  logic [31:0]     shifted;
  logic [31:0]     load_val;

  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wd;

  assign widx      = address[AW+1:2];
  assign lane      = address[1:0];
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign read_Data = rdata_q;
  assign rsp_error = err_q;

  // Decode faults and build the extended load value from the addressed word
  always_comb begin
    oob     = {1'b0, address} >= (ADDR_WIDTH+1)'(4 * DEPTH);
    req_err = 1'b1;
    case (req_size)
      2'b00:   req_err = oob;
      2'b01:   req_err = oob | lane[0];
      2'b10:   req_err = oob | (|lane);
      default: req_err = 1'b1;
    endcase
    shifted  = mem_q[widx] >> {lane, 3'b000};
    load_val = shifted;
    unique case (1'b1)
      (req_size == 2'b00):
        load_val = req_unsigned ? {24'b0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      (req_size == 2'b01):
        load_val = req_unsigned ? {16'b0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default:
        load_val = shifted;
    endcase
  end

  // Select the memory write port: clearing sweep or an accepted store
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = widx;
    mem_be  = 4'b0000;
    mem_wd  = write_Data << {lane, 3'b000};
    if (state_q == INIT) begin
      mem_we  = 1'b1;
      mem_idx = cnt_q;
      mem_be  = 4'b1111;
      mem_wd  = 32'b0;
    end else if (state_q == IDLE && req_valid && req_write && !req_err) begin
      mem_we = 1'b1;
      case (req_size)
        2'b00:   mem_be = 4'b0001 << lane;
        2'b01:   mem_be = 4'b0011 << lane;
        default: mem_be = 4'b1111;
      endcase
    end
  end

  // Byte-lane write into the storage array
  always_ff @(posedge clock) begin
    if (mem_we && reset_n) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  // Next state, clear counter and registered response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (req_valid) begin
          state_d = RESP;
          err_d   = req_err;
          rdata_d = (req_err || req_write) ? 32'b0 : load_val;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if (INIT_CLEAR) state_q <= INIT;
      else            state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// Scoreboard bench for sized_data_memory: directed cases plus random
// traffic against a byte-array reference model.
module tb_sized_data_memory;

  localparam int DEPTH = 64;
  localparam int NBYTE = 4 * DEPTH;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] write_Data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] read_Data;
  logic        rsp_error;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mem_m [NBYTE];
  int         n_vec;
  int         n_mis;

  sized_data_memory #(
    .DEPTH(DEPTH),
    .ADDR_WIDTH(32),
    .INIT_CLEAR(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .address(address),
    .write_Data(write_Data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .read_Data(read_Data),
    .rsp_error(rsp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NBYTE; i++) mem_m[i] = 8'h00;
  endtask

  // Reference: memory is a flat little-endian byte array
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
    int nb;
    nb = 1 << sz;
    er = (a >= NBYTE) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
         (sz == 2'd2 && a[1:0] != 2'b00);
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mem_m[a + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) rd[8*i +: 8] = mem_m[a + i];
        if (!u && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
      end
    end
  endtask

  // Issue one request; entered and left at posedge+1 with the DUT idle
  task automatic req(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d,
                     input int stall, input bit chk = 1'b0,
                     input logic [31:0] ev = 32'h0, input logic ee = 1'b0);
    logic [31:0] rd;
    logic        er;
    int          n;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    address      = a;
    write_Data   = d;
    req_valid    = 1'b1;
    rsp_ready    = (stall == 0);
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    @(posedge clock);
    model(w, sz, u, a, d, rd, er);
    if (chk) begin
      rd = ev;
      er = ee;
    end
    exp_q.push_back('{rd: rd, err: er});
    #1;
    req_valid = 1'b0;
    repeat (stall) begin
      @(posedge clock);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Count cycles with req_ready low after reset release
  task automatic count_init(input string nm);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(posedge clock);
      #1;
    end
    check(nm, 32'(n), 32'(DEPTH));
  endtask

  // Monitor: compare each consumed response against the scoreboard
  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", read_Data, mon_e.rd);
        check("rsp_error", 32'(rsp_error), 32'(mon_e.err));
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    n_vec        = 0;
    n_mis        = 0;
    reset_n      = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    address      = 32'h0;
    write_Data   = 32'h0;
    rsp_ready    = 1'b1;
    clear_model();

    #3 reset_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_read_data", read_Data, 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'h0);
    #18 reset_n = 1'b1;
    count_init("init_cycles");

    req(0, 2'd2, 0, 32'h10, 0, 0, 1, 32'h0, 0);

    req(1, 2'd2, 0, 32'h04, 32'h800080FF, 0);
    req(0, 2'd0, 1, 32'h04, 0, 0, 1, 32'h000000FF, 0);
    req(0, 2'd0, 0, 32'h05, 0, 0, 1, 32'hFFFFFF80, 0);
    req(0, 2'd1, 0, 32'h06, 0, 0, 1, 32'hFFFF8000, 0);
    req(0, 2'd1, 1, 32'h06, 0, 0, 1, 32'h00008000, 0);

    req(1, 2'd2, 0, 32'h08, 32'h11223344, 0);
    req(1, 2'd0, 0, 32'h09, 32'h000000AB, 0);
    req(0, 2'd2, 0, 32'h08, 0, 0, 1, 32'h1122AB44, 0);
    req(1, 2'd1, 0, 32'h0A, 32'h0000BEEF, 1);
    req(0, 2'd2, 0, 32'h08, 0, 0, 1, 32'hBEEFAB44, 0);

    req(0, 2'd2, 0, 32'h0A, 0, 0, 1, 32'h0, 1);
    req(1, 2'd1, 0, 32'h05, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
    req(0, 2'd3, 0, 32'h04, 0, 0, 1, 32'h0, 1);
    req(0, 2'd2, 0, 32'h100, 0, 0, 1, 32'h0, 1);
    req(0, 2'd2, 0, 32'h04, 0, 0, 1, 32'h800080FF, 0);

    req_write    = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    address      = 32'h08;
    req_valid    = 1'b1;
    rsp_ready    = 1'b0;
    @(posedge clock);
    exp_q.push_back('{rd: 32'hBEEFAB44, err: 1'b0});
    #1 req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_valid", 32'(rsp_valid), 32'h1);
      check("stall_data", read_Data, 32'hBEEFAB44);
      check("stall_error", 32'(rsp_error), 32'h0);
      check("stall_ready", 32'(req_ready), 32'h0);
      if (i == 0) begin
        req_write  = 1'b1;
        address    = 32'h08;
        write_Data = 32'hDEADBEEF;
        req_valid  = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("stall_exit_valid", 32'(rsp_valid), 32'h0);
    check("stall_exit_ready", 32'(req_ready), 32'h1);
    req(0, 2'd2, 0, 32'h08, 0, 0, 1, 32'hBEEFAB44, 0);

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
      a  = ($urandom % 10 == 0) ? ($urandom % 512) : ($urandom % NBYTE);
      if ($urandom % 5 != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      req(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
          int'($urandom % 3));
    end

    for (int w = 0; w < DEPTH; w++) req(1, 2'd2, 0, 32'(4 * w), $urandom, 0);

    req_write = 1'b0;
    req_size  = 2'd2;
    address   = 32'h0;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    #2;
    check("resp_before_reset", 32'(rsp_valid), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_resp_valid", 32'(rsp_valid), 32'h0);
    check("rst_resp_data", read_Data, 32'h0);
    check("rst_resp_error", 32'(rsp_error), 32'h0);
    check("rst_resp_ready", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    clear_model();
    @(posedge clock);
    #3 reset_n = 1'b1;

    repeat (10) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("rst_init_ready", 32'(req_ready), 32'h0);
    check("rst_init_valid", 32'(rsp_valid), 32'h0);
    #1 reset_n = 1'b1;
    count_init("init_restart");

    for (int w = 0; w < DEPTH; w++) req(0, 2'd2, 0, 32'(4 * w), 0, 0);

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sized_data_memory.md
SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 Parameter: DEPTH, default 64, number of 32-bit words; power of two, >= 2.
REQ-002 Parameter: ADDR_WIDTH, default 32, width of the byte address.
REQ-003 Parameter: INIT_CLEAR, default 1; 1 = zero memory after reset, 0 = skip clearing.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-010 req_unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-011 address  input  ADDR_WIDTH  byte address, little-endian.
REQ-012 write_Data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 read_Data  output  32  load result; 0 for stores and errored requests.
REQ-016 rsp_error  output  1  request faulted; valid only while rsp_valid is 1.

Function
REQ-017 FSM states: INIT, IDLE and RESP.
REQ-018 INIT: a counter writes 0 to word 0..DEPTH-1, one word per cycle, then the FSM goes to IDLE; req_ready is 0 in INIT.
REQ-019 With INIT_CLEAR=0, reset leads directly to IDLE and memory contents are unchanged.
REQ-020 req_ready is 1 only in IDLE; a request is accepted on an edge with req_valid=1 and req_ready=1; all request fields are captured at acceptance.
REQ-021 Acceptance moves IDLE->RESP; RESP->IDLE on an edge with rsp_ready=1; rsp_valid is 1 exactly in RESP (one-cycle latency, at most one outstanding request).
REQ-022 rsp_valid, read_Data and rsp_error hold stable in RESP until rsp_ready=1.
REQ-023 Word index = address[log2(DEPTH)+1:2]; lane = address[1:0].
REQ-024 Error: address >= 4*DEPTH, or req_size=11, or a half access with address[0]=1, or a word access with address[1:0]!=00.
REQ-025 Errored request: no memory write, rsp_error=1, read_Data=0.
REQ-026 Store, no error: memory is updated at the acceptance edge, and only the addressed byte lanes change (byte = 1 lane, half = lanes 2*address[1]+{0,1}, word = all lanes); response is read_Data=0, rsp_error=0.
REQ-027 Load, no error: the word is read at acceptance; the selected lane(s) are right-aligned and then zero- or sign-extended per req_unsigned; word loads ignore req_unsigned.
REQ-028 read_Data and rsp_error are registered outputs.

Reset
REQ-029 reset_n=0 forces, immediately and asynchronously: state=INIT (or IDLE if INIT_CLEAR=0), INIT counter=0, req_ready=0 (1 if INIT_CLEAR=0), rsp_valid=0, rsp_error=0, read_Data=0.
REQ-030 Reset during INIT restarts clearing from word 0; reset during RESP discards the pending response; a store already accepted remains in memory.

Verification
REQ-031 Release reset, DEPTH=64 -> req_ready=0 for exactly 64 cycles, then 1; LW 0x10 -> read_Data=0x00000000, rsp_error=0.
REQ-032 SW 0x800080FF @0x04 -> LBU 0x04 = 0x000000FF; LB 0x05 = 0xFFFFFF80; LH 0x06 = 0xFFFF8000; LHU 0x06 = 0x00008000.
REQ-033 SW 0x11223344 @0x08, then SB 0x000000AB @0x09 -> LW 0x08 = 0x1122AB44; SH 0x0000BEEF @0x0A -> LW 0x08 = 0xBEEFAB44.
REQ-034 LW 0x0A, SH @0x05, req_size=11, LW 0x100 (DEPTH=64) -> each gives rsp_error=1 and read_Data=0; a following LW 0x04 still returns its prior value.
REQ-035 Hold rsp_ready=0 for 3 cycles after LW -> rsp_valid, read_Data and rsp_error stay stable, req_ready=0, and a req_valid pulse is ignored; rsp_ready=1 -> IDLE on the next edge.
REQ-036 Assert reset_n=0 during RESP and again during INIT -> rsp_valid drops to 0 without waiting for a clock edge; INIT restarts at word 0 and runs the full 64 cycles.
